branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Branch history table (BHT) of 2-bit saturating counters.
- Sits in IF and supplies a taken/not-taken prediction for the fetch PC.
- Trained from ID with the resolved branch outcome, i.e. the comparator's judge signal, plus the prediction that travelled with that instruction.
- Flags mispredictions to the hazard/flush logic one cycle after resolution.

Parameters:
- INDEX_BITS, 6, log2 of BHT entries (64 entries); index = pc[INDEX_BITS+1:2].
- INIT_STATE, 2'b01, counter value loaded on reset and on clear (weakly not-taken).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pred_pc  input  32  IF-stage PC to predict.
- pred_taken  output  1  combinational prediction for pred_pc.
- upd_valid  input  1  ID has resolved a conditional branch this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  resolved outcome (1 = taken).
- upd_pred  input  1  prediction previously issued for this branch.
- clear  input  1  synchronous: reinitialise whole table.
- mispredict  output  1  registered; high one cycle after a valid update whose upd_taken != upd_pred.
- stat_branches  output  32  resolved-branch count (only with BP_STATS_EN).
- stat_mispredicts  output  32  mispredict count (only with BP_STATS_EN).

Behaviour:
- Storage: 2^INDEX_BITS counters, held in flops rather than RAM, because the reset is asynchronous.
- Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.
- Prediction:
  - pred_taken = bht[pred_pc[INDEX_BITS+1:2]][1].
  - Purely combinational, 0-cycle latency.
  - pred_pc[1:0] and pc bits above INDEX_BITS+1 are ignored; aliasing is accepted.
- Update, on the rising edge when upd_valid = 1 and clear = 0, at index upd_pc[INDEX_BITS+1:2]:
  - taken: counter increments, saturating at 11.
  - not taken: counter decrements, saturating at 00.
  - All other entries unchanged.
- upd_valid = 0: no table change; upd_pc, upd_taken and upd_pred are don't-care.
- Read/write same index in the same cycle:
  - pred_taken reflects the pre-edge value; there is no bypass.
  - The new value is visible from the next cycle.
- Different indices in the same cycle are independent.
- mispredict:
  - Flop, next value = upd_valid & ~clear & (upd_taken ^ upd_pred).
  - Exactly a one-cycle pulse per offending update.
  - Back-to-back mispredicting updates hold it high on consecutive cycles.
- clear:
  - All entries go to INIT_STATE on the next edge.
  - Overrides a simultaneous update, which is dropped; mispredict next cycle = 0.
  - Stats are not affected.
- Reset (rst_n = 0, asynchronous, also valid mid-operation):
  - All entries = INIT_STATE and mispredict = 0.
  - Stats = 0.
  - pred_taken therefore = INIT_STATE[1] (0 by default) immediately during reset.
- Release of rst_n: first update may occur on the first edge after release.
- Width rules: INDEX_BITS range 1..10; pc bits beyond [31] are not applicable.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - stat_branches increments by 1 on each accepted update (upd_valid & ~clear).
  - stat_mispredicts increments by 1 when that update also mispredicts.
  - Both wrap modulo 2^32; reset to 0 on rst_n only.
- Undefined: stat_* ports absent, no counter logic synthesised; all other behaviour identical.

Test Plan:
- Reset, then pred_pc = 0x0000_0040 -> pred_taken = 0; assert rst_n low mid-run after training index 16 to 11 -> pred_taken = 0 immediately, mispredict = 0.
- Three updates upd_pc = 0x100, taken = 1, upd_pred = 0 -> counter 01→10→11→11 (saturates); pred_taken at 0x100 goes 1 from the cycle after the first update; mispredict pulses each cycle.
- Four not-taken updates at 0x100 from state 11 -> 10, 01, 00, 00; pred_taken 1, 0, 0, 0; upd_pred matching outcome -> mispredict stays 0.
- Same-cycle pred_pc = upd_pc = 0x200 (state 01), upd_taken = 1 -> pred_taken = 0 that cycle, 1 next cycle; aliasing check: 0x200 and 0x300 (INDEX_BITS = 6) share an entry.
- clear together with a valid mispredicting update at 0x100 -> entry 0x100 = 01, update dropped, mispredict = 0 next cycle.
- BP_STATS_EN: 10 updates, 3 mispredicting, one issued with clear = 1 (the cleared one non-mispredicting) -> stat_branches = 9, stat_mispredicts = 3; preload near 0xFFFF_FFFF -> wraps to 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch history table of 2-bit saturating counters: combinational IF-stage prediction,
// ID-stage training and a registered mispredict flag. Define BP_STATS_EN for branch/mispredict counters.
module branch_predictor #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_pred,
    input  logic        clear,
    output logic        mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic                  upd_accept;
    logic                  mispredict_next;
    logic [ENTRIES-1:0]    taken_vec;
    logic                  mispredict_reg;

    assign pred_idx        = pred_pc[INDEX_BITS+1:2];
    assign upd_idx         = upd_pc[INDEX_BITS+1:2];
    assign upd_accept      = upd_valid & ~clear;
    assign mispredict_next = upd_accept & (upd_taken ^ upd_pred);

    // Only the index field of each PC matters; the remaining bits are deliberately dropped.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                              upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

    // Each counter lives in its own generate scope so the asynchronous reset maps onto plain flops.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [1:0] cnt_reg;
            logic [1:0] cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (clear) begin
                    cnt_next = INIT_STATE;
                end else if (upd_valid && (upd_idx == INDEX_BITS'(gi))) begin
                    if (upd_taken) begin
                        if (cnt_reg != 2'b11) begin
                            cnt_next = cnt_reg + 2'd1;
                        end
                    end else if (cnt_reg != 2'b00) begin
                        cnt_next = cnt_reg - 2'd1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= INIT_STATE;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign taken_vec[gi] = cnt_reg[1];
        end
    endgenerate

    // No bypass: a same-cycle update is only visible after the edge.
    assign pred_taken = taken_vec[pred_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_reg <= 1'b0;
        end else begin
            mispredict_reg <= mispredict_next;
        end
    end

    assign mispredict = mispredict_reg;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispredicts_reg;

    // Clear leaves the statistics alone; only rst_n zeroes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_reg    <= 32'd0;
            stat_mispredicts_reg <= 32'd0;
        end else begin
            if (upd_accept) begin
                stat_branches_reg <= stat_branches_reg + 32'd1;
            end
            if (mispredict_next) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against an integer-array reference of the counter table.
module tb_branch_predictor;

    localparam int IB      = 6;
    localparam int ENTRIES = 1 << IB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred;
    logic        clear;
    logic        mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int          checks   = 0;
    int          failures = 0;

    // Reference model: counter values 0..3 per entry, plus expected flag and stats.
    int          bht_m [ENTRIES];
    logic        exp_mis;
    logic [31:0] exp_br;
    logic [31:0] exp_mp;

    branch_predictor #(.INDEX_BITS(IB), .INIT_STATE(2'b01)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pred_pc    (pred_pc),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_pred   (upd_pred),
        .clear      (clear),
        .mispredict (mispredict)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic model_pred(input logic [31:0] pc);
        return (bht_m[idx_of(pc)] >= 2);
    endfunction

    task automatic reset_model();
        for (int k = 0; k < ENTRIES; k++) bht_m[k] = 1;
        exp_mis = 1'b0;
        exp_br  = 32'd0;
        exp_mp  = 32'd0;
    endtask

    // Advance one clock with the current inputs and move the model along with it.
    task automatic tick();
        int   i;
        logic v;
        logic t;
        logic c;
        logic nm;
        i  = idx_of(upd_pc);
        v  = upd_valid;
        t  = upd_taken;
        c  = clear;
        nm = v && !c && (upd_taken != upd_pred);
        @(posedge clk);
        if (c) begin
            for (int k = 0; k < ENTRIES; k++) bht_m[k] = 1;
        end else if (v) begin
            if (t) bht_m[i] = (bht_m[i] == 3) ? 3 : bht_m[i] + 1;
            else   bht_m[i] = (bht_m[i] == 0) ? 0 : bht_m[i] - 1;
            exp_br = exp_br + 32'd1;
            if (nm) exp_mp = exp_mp + 32'd1;
        end
        exp_mis = nm;
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                           input logic p, input logic c);
        upd_valid = v;
        upd_pc    = pc;
        upd_taken = t;
        upd_pred  = p;
        clear     = c;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        pred_pc = 32'h0000_0040;
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset_model();
        #3;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL reset_pred: got %b want 0", pred_taken);
        end
        checks++;
        if (mispredict !== 1'b0) begin
            failures++;
            $display("FAIL reset_mispredict: got %b want 0", mispredict);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_pred: got %b want 0", pred_taken);
        end
        $display("test_reset: pred=%b mispredict=%b", pred_taken, mispredict);
    endtask

    task automatic test_taken_saturate();
        pred_pc = 32'h0000_0100;
        set_upd(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL taken_initial_pred: got %b want 0", pred_taken);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (pred_taken !== model_pred(pred_pc)) begin
                failures++;
                $display("FAIL taken_pred[%0d]: got %b want %b", n, pred_taken, model_pred(pred_pc));
            end
            checks++;
            if (mispredict !== 1'b1) begin
                failures++;
                $display("FAIL taken_mispredict[%0d]: got %b want 1", n, mispredict);
            end
            $display("taken update %0d: pred=%b mispredict=%b", n, pred_taken, mispredict);
        end
    endtask

    task automatic test_not_taken_saturate();
        pred_pc = 32'h0000_0100;
        set_upd(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (pred_taken !== model_pred(pred_pc)) begin
                failures++;
                $display("FAIL nt_pred[%0d]: got %b want %b", n, pred_taken, model_pred(pred_pc));
            end
            checks++;
            if (mispredict !== 1'b0) begin
                failures++;
                $display("FAIL nt_mispredict[%0d]: got %b want 0", n, mispredict);
            end
            $display("not-taken update %0d: pred=%b mispredict=%b", n, pred_taken, mispredict);
        end
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_same_cycle();
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        pred_pc = 32'h0000_0200;
        set_upd(1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_pre: got %b want 0", pred_taken);
        end
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (pred_taken !== model_pred(pred_pc)) begin
            failures++;
            $display("FAIL same_cycle_post: got %b want %b", pred_taken, model_pred(pred_pc));
        end
        pred_pc = 32'h0000_0300;
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL alias_0x300: got %b want 1", pred_taken);
        end
        pred_pc = 32'h0000_0204;
        #1;
        checks++;
        if (pred_taken !== model_pred(pred_pc)) begin
            failures++;
            $display("FAIL neighbour_0x204: got %b want %b", pred_taken, model_pred(pred_pc));
        end
        $display("test_same_cycle: alias pred=%b neighbour pred=%b", model_pred(32'h300), pred_taken);
    endtask

    task automatic test_clear();
        set_upd(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        pred_pc = 32'h0000_0100;
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL clear_pretrain: got %b want 1", pred_taken);
        end
        set_upd(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (mispredict !== 1'b0) begin
            failures++;
            $display("FAIL clear_mispredict: got %b want 0", mispredict);
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL clear_entry_0x100: got %b want 0", pred_taken);
        end
        pred_pc = 32'h0000_0200;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL clear_entry_0x200: got %b want 0", pred_taken);
        end
        tick();
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL clear_hold: got %b want 0", pred_taken);
        end
        $display("test_clear: entry 0x100 pred=%b mispredict=%b", model_pred(32'h100), mispredict);
    endtask

    task automatic test_async_reset();
        pred_pc = 32'h0000_0040;
        set_upd(1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (pred_taken !== 1'b1 || mispredict !== 1'b1) begin
            failures++;
            $display("FAIL async_pretrain: got pred=%b mis=%b want pred=1 mis=1", pred_taken, mispredict);
        end
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_pred: got %b want 0", pred_taken);
        end
        checks++;
        if (mispredict !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_mispredict: got %b want 0", mispredict);
        end
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        $display("test_async_reset: pred=%b mispredict=%b", pred_taken, mispredict);
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int n = 0; n < 400; n++) begin
            pc = $urandom;
            if (n % 2 == 0) pc = pc & 32'hFFFF_F01F;
            set_upd(($urandom_range(3, 0) != 0), pc, 1'($urandom), 1'($urandom),
                    ($urandom_range(39, 0) == 0));
            pred_pc = (n % 3 == 0) ? pc : $urandom;
            #1;
            checks++;
            if (pred_taken !== model_pred(pred_pc)) begin
                failures++;
                $display("FAIL rand_pred[%0d]: pc=%h got %b want %b", n, pred_pc, pred_taken, model_pred(pred_pc));
            end
            tick();
            checks++;
            if (mispredict !== exp_mis) begin
                failures++;
                $display("FAIL rand_mispredict[%0d]: got %b want %b", n, mispredict, exp_mis);
            end
`ifdef BP_STATS_EN
            checks++;
            if (stat_branches !== exp_br || stat_mispredicts !== exp_mp) begin
                failures++;
                $display("FAIL rand_stats[%0d]: got %0d/%0d want %0d/%0d", n,
                         stat_branches, stat_mispredicts, exp_br, exp_mp);
            end
`endif
            $display("rand %0d: v=%b clr=%b upc=%h t=%b p=%b ppc=%h pred=%b mis=%b", n, upd_valid,
                     clear, upd_pc, upd_taken, upd_pred, pred_pc, pred_taken, mispredict);
        end
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef BP_STATS_EN
    task automatic test_stats();
        logic [2:0] plan [10];
        // {taken, pred, clear}: entries 1, 4, 7 mispredict; entry 5 is cleared and matches.
        plan = '{3'b000, 3'b100, 3'b110, 3'b000, 3'b010,
                 3'b111, 3'b110, 3'b100, 3'b000, 3'b110};
        rst_n = 1'b0;
        #2;
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            set_upd(1'b1, 32'h0000_0100 + 32'(n * 4), plan[n][2], plan[n][1], plan[n][0]);
            tick();
            $display("stats update %0d: branches=%0d mispredicts=%0d", n, stat_branches, stat_mispredicts);
        end
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (stat_branches !== 32'd9) begin
            failures++;
            $display("FAIL stat_branches: got %0d want 9", stat_branches);
        end
        checks++;
        if (stat_mispredicts !== 32'd3) begin
            failures++;
            $display("FAIL stat_mispredicts: got %0d want 3", stat_mispredicts);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_taken_saturate();
        test_not_taken_saturate();
        test_same_cycle();
        test_clear();
        test_async_reset();
        test_random();
`ifdef BP_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
